// File: rtl/controle_esteira.sv
// rtl/controle_esteira.sv - bottle conveyor/filling initiator for the sealing handshake
//
// Moves one bottle at a time through fill and seal positions, presents
// gar/pos to the sealing FSM, waits for done/alarme, ejects and counts.
// All outputs are registered from the next state (Moore, no output glitches).
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start, stop   run request / finish-current-bottle request (levels)
//   done, alarme  sealing FSM status inputs
//   motor         conveyor motor enable
//   valvula       filling valve open
//   gar, pos      bottle present / bottle held at sealing station
//   erro          sticky seal-timeout flag
//   cont_garrafas sealed bottle count (8-bit, wraps)
//   cont_duzias   completed dozen count (8-bit, wraps)
//   duzia         one-cycle pulse when a dozen completes

module controle_esteira #(
    parameter int MOVE_CYCLES  = 4,
    parameter int FILL_CYCLES  = 6,
    parameter int SEAL_TIMEOUT = 32,
    parameter int DOZEN        = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       done,
    input  logic       alarme,
    output logic       motor,
    output logic       valvula,
    output logic       gar,
    output logic       pos,
    output logic       erro,
    output logic [7:0] cont_garrafas,
    output logic [7:0] cont_duzias,
    output logic       duzia
);

    localparam logic [7:0] MOVE_LAST = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] FILL_LAST = 8'(FILL_CYCLES - 1);
    localparam logic [7:0] SEAL_LAST = 8'(SEAL_TIMEOUT - 1);
    localparam logic [7:0] DZ_LAST   = 8'(DOZEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_FILL,
        S_FILL,
        S_MOVE_SEAL,
        S_WAIT_SEAL,
        S_HALT,
        S_EJECT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] timer;
    logic [7:0] dz_cnt;
    logic       timed;
    logic       erro_set;
    logic       count_en;
    logic       run_ok;

    assign run_ok = start && !stop;

    always_comb begin
        state_next = state;
        timed      = 1'b0;
        erro_set   = 1'b0;
        count_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_ok && !erro) state_next = S_MOVE_FILL;
            end
            S_MOVE_FILL: begin
                timed = 1'b1;
                if (timer == MOVE_LAST) state_next = S_FILL;
            end
            S_FILL: begin
                timed = 1'b1;
                if (timer == FILL_LAST) state_next = S_MOVE_SEAL;
            end
            S_MOVE_SEAL: begin
                timed = 1'b1;
                if (timer == MOVE_LAST) state_next = S_WAIT_SEAL;
            end
            S_WAIT_SEAL: begin
                timed = 1'b1;
                // alarme outranks done so a simultaneous pair parks in HALT
                if (alarme) begin
                    state_next = S_HALT;
                end else if (done) begin
                    state_next = S_EJECT;
                end else if (timer == SEAL_LAST) begin
                    erro_set   = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
                // a timeout error is only cleared by reset
                if (!erro && !alarme) state_next = S_WAIT_SEAL;
            end
            S_EJECT: begin
                timed = 1'b1;
                if (timer == MOVE_LAST) begin
                    count_en   = 1'b1;
                    state_next = run_ok ? S_MOVE_FILL : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= 8'd0;
        end else begin
            state <= state_next;
            if (state_next != state) timer <= 8'd0;
            else if (timed)          timer <= timer + 8'd1;
        end
    end

    // outputs decoded from the next state so they are valid in the entry cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor   <= 1'b0;
            valvula <= 1'b0;
            gar     <= 1'b0;
            pos     <= 1'b0;
            erro    <= 1'b0;
        end else begin
            motor   <= (state_next == S_MOVE_FILL) || (state_next == S_MOVE_SEAL) ||
                       (state_next == S_EJECT);
            valvula <= (state_next == S_FILL);
            gar     <= (state_next == S_WAIT_SEAL) || (state_next == S_HALT) ||
                       (state_next == S_EJECT);
            pos     <= (state_next == S_WAIT_SEAL) || (state_next == S_HALT);
            erro    <= erro || erro_set;
        end
    end

    // dz_cnt tracks bottles mod DOZEN independently of the wrapping 8-bit count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont_garrafas <= 8'd0;
            cont_duzias   <= 8'd0;
            dz_cnt        <= 8'd0;
            duzia         <= 1'b0;
        end else begin
            duzia <= 1'b0;
            if (count_en) begin
                cont_garrafas <= cont_garrafas + 8'd1;
                if (dz_cnt == DZ_LAST) begin
                    dz_cnt      <= 8'd0;
                    cont_duzias <= cont_duzias + 8'd1;
                    duzia       <= 1'b1;
                end else begin
                    dz_cnt <= dz_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_controle_esteira.sv
// tb/tb_controle_esteira.sv - self-checking bench for controle_esteira

module tb_controle_esteira;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       done = 1'b0;
    logic       alarme = 1'b0;
    logic       motor, valvula, gar, pos, erro, duzia;
    logic [7:0] cont_garrafas, cont_duzias;

    int checks = 0;
    int errors = 0;

    controle_esteira #(
        .MOVE_CYCLES(4), .FILL_CYCLES(6), .SEAL_TIMEOUT(32), .DOZEN(12)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .done(done),
        .alarme(alarme), .motor(motor), .valvula(valvula), .gar(gar), .pos(pos),
        .erro(erro), .cont_garrafas(cont_garrafas), .cont_duzias(cont_duzias),
        .duzia(duzia)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       done;
        logic       alarme;
        int         n;
        logic [4:0] exp;   // {motor, valvula, gar, pos, erro}
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [4:0] outs();
        return {motor, valvula, gar, pos, erro};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos();
        int n = 0;
        while (pos !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("wait_pos", {31'd0, pos}, 32'd1);
    endtask

    task automatic run_bottle(input logic [7:0] exp_cnt, input logic exp_dz);
        start = 1'b1;
        wait_pos();
        start = 1'b0;
        done  = 1'b1;
        step();
        done  = 1'b0;
        repeat (3) begin
            step();
            chk("dz_eject", {31'd0, duzia}, 32'd0);
        end
        step();
        chk("dz_cnt", {24'd0, cont_garrafas}, {24'd0, exp_cnt});
        chk("dz_pulse", {31'd0, duzia}, {31'd0, exp_dz});
        step();
        chk("dz_after", {31'd0, duzia}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // first bottle, cycle by cycle: 4 move, 6 fill, 4 move, 1 wait, 4 eject
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 5'b10000, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6, 5'b01000, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 5'b10000, 8'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 5'b00110, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 5'b10100, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 5'b10100, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 5'b00000, 8'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 5'b00000, 8'd1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 5'b00000, 8'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {27'd0, outs()}, 32'd0);
        chk("rst_cnt", {16'd0, cont_garrafas, cont_duzias}, 32'd0);
        chk("rst_duzia", {31'd0, duzia}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_outs", {27'd0, outs()}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            start  = tbl[i].start;
            stop   = tbl[i].stop;
            done   = tbl[i].done;
            alarme = tbl[i].alarme;
            for (int j = 0; j < tbl[i].n; j++) begin
                step();
                chk($sformatf("vec%0d_outs", i), {27'd0, outs()}, {27'd0, tbl[i].exp});
                chk($sformatf("vec%0d_cnt", i), {24'd0, cont_garrafas}, {24'd0, tbl[i].cnt});
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        done  = 1'b0;

        // bottles 2..12: duzia only on the 11->12 transition
        for (int k = 2; k <= 12; k++) run_bottle(8'(k), k == 12);
        chk("duzias_1", {24'd0, cont_duzias}, 32'd1);

        // alarme holds the bottle, then sealing resumes
        start = 1'b1;
        wait_pos();
        start  = 1'b0;
        alarme = 1'b1;
        repeat (10) begin
            step();
            chk("halt_hold", {29'd0, motor, gar, pos}, 32'b011);
        end
        alarme = 1'b0;
        step();
        chk("halt_back", {29'd0, motor, gar, pos}, 32'b011);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("alarm_eject", {29'd0, motor, gar, pos}, 32'b110);
        repeat (4) step();
        chk("alarm_cnt", {24'd0, cont_garrafas}, 32'd13);
        chk("alarm_outs", {27'd0, outs()}, 32'd0);
        chk("alarm_duzia", {31'd0, duzia}, 32'd0);

        // start drops and stop rises during FILL: bottle still completes
        start = 1'b1;
        repeat (5) step();
        chk("fill_valve", {31'd0, valvula}, 32'd1);
        start = 1'b0;
        stop  = 1'b1;
        wait_pos();
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (4) step();
        chk("stop_cnt", {24'd0, cont_garrafas}, 32'd14);
        chk("stop_idle", {27'd0, outs()}, 32'd0);
        repeat (2) step();
        chk("stop_stay", {27'd0, outs()}, 32'd0);
        stop = 1'b0;

        // asynchronous reset in the middle of FILL
        start = 1'b1;
        repeat (6) step();
        chk("pre_rst_valve", {31'd0, valvula}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_outs", {27'd0, outs()}, 32'd0);
        chk("arst_cnt", {16'd0, cont_garrafas, cont_duzias}, 32'd0);
        step();
        reset = 1'b0;

        // seal timeout: erro after 32 WAIT_SEAL cycles, sticky until reset
        wait_pos();
        repeat (31) step();
        chk("tmo_before", {27'd0, outs()}, 32'b00110);
        step();
        chk("tmo_erro", {27'd0, outs()}, 32'b00111);
        done = 1'b1;
        repeat (5) step();
        done = 1'b0;
        chk("tmo_stuck", {27'd0, outs()}, 32'b00111);
        chk("tmo_cnt", {24'd0, cont_garrafas}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("tmo_rst", {27'd0, outs()}, 32'd0);
        start = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("final_idle", {27'd0, outs()}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
